// File: rtl/shift_add_mult_ctrl.sv
// Sequencing controller for a shift-and-add multiplier: walks the multiplier one bit
// per iteration, exits early once it is zero, and drives falling-edge-registered strobes.
module shift_add_mult_ctrl #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mplr_lsb,
    input  logic          mplr_zero,
    output logic          ld_mcand,
    output logic          ld_mplr,
    output logic          shift_en,
    output logic          acc_clr,
    output logic          acc_ld,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic [2:0]    state_dbg
);

    // Handshake: start is a request sampled only in IDLE (no ready signal; it is ignored
    // while busy). done is a one-cycle pulse in the DONE state marking a valid product.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] N_CNT = CW'(N);

    state_t state;
    state_t state_next;
    logic   ld_mcand_d;
    logic   ld_mplr_d;
    logic   shift_en_d;
    logic   acc_clr_d;
    logic   acc_ld_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == S_LOAD)
                count <= '0;
            else if (state == S_SHIFT && count != N_CNT)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        ld_mcand_d = 1'b0;
        ld_mplr_d  = 1'b0;
        shift_en_d = 1'b0;
        acc_clr_d  = 1'b0;
        acc_ld_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                ld_mcand_d = 1'b1;
                ld_mplr_d  = 1'b1;
                shift_en_d = 1'b1;
                acc_clr_d  = 1'b1;
                state_next = S_TEST;
            end
            S_TEST: begin
                if (count == N_CNT || mplr_zero)
                    state_next = S_DONE;
                else if (mplr_lsb)
                    state_next = S_ADD;
                else
                    state_next = S_SHIFT;
            end
            S_ADD: begin
                acc_ld_d   = 1'b1;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en_d = 1'b1;
                state_next = S_TEST;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Strobes change only on the falling edge so they are stable across the whole high
    // phase; the gated datapath clock then fires on the rising edge that ends the state.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ld_mcand <= 1'b0;
            ld_mplr  <= 1'b0;
            shift_en <= 1'b0;
            acc_clr  <= 1'b0;
            acc_ld   <= 1'b0;
        end else begin
            ld_mcand <= ld_mcand_d;
            ld_mplr  <= ld_mplr_d;
            shift_en <= shift_en_d;
            acc_clr  <= acc_clr_d;
            acc_ld   <= acc_ld_d;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: a behavioural datapath closes the loop, directed
// vectors check latency, strobe counts and product, plus reset and back-to-back sequences.
module tb_shift_add_mult_ctrl;

    localparam int N  = 16;
    localparam int CW = 5;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mplr_lsb;
    logic          mplr_zero;
    logic          ld_mcand;
    logic          ld_mplr;
    logic          shift_en;
    logic          acc_clr;
    logic          acc_ld;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic [2:0]    state_dbg;

    shift_add_mult_ctrl #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mplr_lsb(mplr_lsb), .mplr_zero(mplr_zero),
        .ld_mcand(ld_mcand), .ld_mplr(ld_mplr), .shift_en(shift_en),
        .acc_clr(acc_clr), .acc_ld(acc_ld),
        .busy(busy), .done(done), .count(count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: registers clock on rising edges where their strobe is high.
    logic [15:0] mcand_in = '0;
    logic [15:0] mplr_in  = '0;
    logic [31:0] mc_reg;
    logic [15:0] mp_reg;
    logic [31:0] acc_reg;
    int          add_total;
    int          shift_total;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_reg      <= '0;
            mp_reg      <= '0;
            acc_reg     <= '0;
            add_total   <= 0;
            shift_total <= 0;
        end else begin
            if (shift_en) begin
                mc_reg <= ld_mcand ? {16'h0, mcand_in} : (mc_reg << 1);
                mp_reg <= ld_mplr ? mplr_in : (mp_reg >> 1);
                if (!ld_mplr)
                    shift_total <= shift_total + 1;
            end
            if (acc_clr)
                acc_reg <= '0;
            else if (acc_ld) begin
                acc_reg   <= acc_reg + mc_reg;
                add_total <= add_total + 1;
            end
        end
    end

    assign mplr_lsb  = mp_reg[0];
    assign mplr_zero = (mp_reg == 16'h0);

    // Strobe edge monitor: outside reset, strobes may only move while clk is low.
    int strobe_changes = 0;
    int strobe_bad     = 0;
    always @(ld_mcand or ld_mplr or shift_en or acc_clr or acc_ld) begin
        if (rst) begin
            strobe_changes = strobe_changes + 1;
            if (clk)
                strobe_bad = strobe_bad + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        logic [15:0] mcand;
        logic [15:0] mplr;
        logic [31:0] prod;
        int          lat;
        int          adds;
        int          shifts;
        int          cnt;
    } vec_t;

    vec_t vecs[6];

    // Pulses start for one cycle; cycle 1 is LOAD. Returns done latency (-1 on timeout).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                          output int adds, output int shifts, output int cnt,
                          output logic [31:0] prod);
        int cyc;
        int add0;
        int sh0;
        @(negedge clk);
        mcand_in = a;
        mplr_in  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        add0  = add_total;
        sh0   = shift_total;
        cyc   = 1;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat    = done ? cyc : -1;
        adds   = add_total - add0;
        shifts = shift_total - sh0;
        cnt    = int'(count);
        prod   = acc_reg;
    endtask

    initial begin
        int          lat;
        int          adds;
        int          shifts;
        int          cnt;
        int          cyc;
        int          last;
        int          n_done;
        int          act_bits;
        logic [31:0] prod;

        vecs[0] = '{16'hABCD, 16'h0000, 32'h0000_0000,  3,  0,  0,  0};
        vecs[1] = '{16'h00FF, 16'hFFFF, 32'h00FE_FF01, 51, 16, 16, 16};
        vecs[2] = '{16'h0003, 16'h0005, 32'h0000_000F, 11,  2,  3,  3};
        vecs[3] = '{16'h0001, 16'h8000, 32'h0000_8000, 36,  1, 16, 16};
        vecs[4] = '{16'h1234, 16'h0001, 32'h0000_1234,  6,  1,  1,  1};
        vecs[5] = '{16'h0007, 16'h00A0, 32'h0000_0460, 21,  2,  8,  8};

        // Reset state
        #3;
        check("reset_strobes", {59'h0, ld_mcand, ld_mplr, shift_en, acc_clr, acc_ld}, 64'h0);
        check("reset_busy_done", {62'h0, busy, done}, 64'h0);
        check("reset_count", 64'(count), 64'h0);
        check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", {61'h0, busy, shift_en, ld_mcand}, 64'h0);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].mcand, vecs[i].mplr, lat, adds, shifts, cnt, prod);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_adds", i), 64'(adds), 64'(vecs[i].adds));
            check($sformatf("v%0d_shifts", i), 64'(shifts), 64'(vecs[i].shifts));
            check($sformatf("v%0d_count", i), 64'(cnt), 64'(vecs[i].cnt));
            check($sformatf("v%0d_product", i), 64'(prod), 64'(vecs[i].prod));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), {62'h0, done, busy}, 64'h0);
        end

        // Reset asserted during SHIFT with count=5 aborts at once
        @(negedge clk);
        mcand_in = 16'h00FF;
        mplr_in  = 16'hFFFF;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!(state_dbg == ST_SHIFT && count == 5'd5) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach_shift_cnt5", 64'(cyc < 100), 64'h1);
        #1 rst = 1'b0;
        #1;
        check("abort_strobes", {59'h0, ld_mcand, ld_mplr, shift_en, acc_clr, acc_ld}, 64'h0);
        check("abort_busy_done", {62'h0, busy, done}, 64'h0);
        check("abort_count", 64'(count), 64'h0);
        check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clk);
        #1 rst = 1'b1;
        act_bits = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (busy || done || ld_mcand || ld_mplr || shift_en || acc_clr || acc_ld || count != 0)
                act_bits++;
        end
        check("post_reset_quiet", 64'(act_bits), 64'h0);

        // start held high: back-to-back ops every 10 cycles for mplr=3
        @(negedge clk);
        mcand_in = 16'h0011;
        mplr_in  = 16'h0003;
        start    = 1'b1;
        last     = -1;
        n_done   = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (last >= 0)
                    check("b2b_spacing", 64'(c - last), 64'd10);
                else
                    check("b2b_first_latency", 64'(c + 1), 64'd9);
                check("b2b_product", 64'(acc_reg), 64'h33);
                last = c;
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(n_done), 64'd4);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_after", {63'h0, busy}, 64'h0);

        check("strobe_edges_seen", 64'(strobe_changes > 0), 64'h1);
        check("strobe_on_falling_edge", 64'(strobe_bad), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
